riscv_uc: RTL and testbench

- Multi-cycle control unit that sequences the RISC-V datapath (`riscv_dp`).
- Decodes the datapath `opcode` output and drives the datapath control inputs: PC load/reset, memory enables, register-file write, ALU op class and mux selects.
- Runs a fixed FETCH/DECODE/EXEC/MEM/WB state machine per instruction.
- Provides start/halt handshaking so a testbench or top level can launch and stop the core.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/riscv_uc_decode.sv | 25 ++
 rtl/riscv_uc.sv | 174 +++++++++++++++++
 tb/tb_riscv_uc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V multi-cycle control unit: opcodes, ALU
// classes, mux select encodings, FSM state and decoded opcode class types.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] MUX1_RS2   = 2'd0;
  localparam logic [1:0] MUX1_IMM   = 2'd1;
  localparam logic [1:0] MUX2_ALU   = 2'd0;
  localparam logic [1:0] MUX2_MEM   = 2'd1;
  localparam logic [1:0] MUX3_PC1   = 2'd0;
  localparam logic [1:0] MUX3_PCIMM = 2'd1;
  localparam logic [1:0] MUX4_ALU   = 2'd0;
  localparam logic [1:0] MUX4_RS2   = 2'd1;

  typedef enum logic [2:0] {
    UC_IDLE   = 3'd0,
    UC_FETCH  = 3'd1,
    UC_DECODE = 3'd2,
    UC_EXEC   = 3'd3,
    UC_MEM    = 3'd4,
    UC_WB     = 3'd5,
    UC_HALT   = 3'd6
  } uc_state_t;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_R      = 3'd1,
    OP_I      = 3'd2,
    OP_LOAD   = 3'd3,
    OP_STORE  = 3'd4,
    OP_BRANCH = 3'd5,
    OP_HALT   = 3'd6
  } op_class_t;

endpackage

// File: rtl/riscv_uc_decode.sv
// Combinational opcode classifier; unknown opcodes map to OP_NONE with
// illegal_op raised.
module riscv_uc_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       illegal_op
);

  always_comb begin
    op_class   = OP_NONE;
    illegal_op = 1'b0;
    case (opcode)
      OPC_R:      op_class = OP_R;
      OPC_I:      op_class = OP_I;
      OPC_LOAD:   op_class = OP_LOAD;
      OPC_STORE:  op_class = OP_STORE;
      OPC_BRANCH: op_class = OP_BRANCH;
      OPC_SYSTEM: op_class = OP_HALT;
      default:    illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_uc.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with start/halt
// handshake. Define RISCV_UC_PERF_EN to add cycle_cnt/instret_cnt counters.
module riscv_uc
  import riscv_pkg::*;
#(
  parameter bit AUTO_START = 1'b0,
  parameter int PERF_W     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic       branch,
  output logic       pc_load,
  output logic       pc_reset,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_file_write,
  output logic [1:0] alu_op,
  output logic [1:0] select_mux_1,
  output logic [1:0] select_mux_2,
  output logic [1:0] select_mux_3,
  output logic [1:0] select_mux_4,
  output logic       busy,
  output logic       halted,
  output logic       illegal
`ifdef RISCV_UC_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instret_cnt
`endif
);

  uc_state_t state_reg, state_next;
  op_class_t op_q;
  op_class_t dec_class;
  logic      dec_illegal;
  logic      illegal_reg;

  riscv_uc_decode u_decode (
    .opcode     (opcode),
    .op_class   (dec_class),
    .illegal_op (dec_illegal)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      UC_IDLE:   if (start || AUTO_START) state_next = UC_FETCH;
      UC_FETCH:  state_next = UC_DECODE;
      UC_DECODE: begin
        if (dec_illegal || dec_class == OP_HALT) state_next = UC_HALT;
        else                                     state_next = UC_EXEC;
      end
      UC_EXEC: begin
        case (op_q)
          OP_R, OP_I:         state_next = UC_WB;
          OP_LOAD, OP_STORE:  state_next = UC_MEM;
          OP_BRANCH:          state_next = UC_FETCH;
          default:            state_next = UC_HALT;
        endcase
      end
      UC_MEM:    state_next = (op_q == OP_LOAD) ? UC_WB : UC_FETCH;
      UC_WB:     state_next = UC_FETCH;
      UC_HALT:   if (start) state_next = UC_IDLE;
      default:   state_next = UC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= UC_IDLE;
      op_q        <= OP_NONE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == UC_DECODE) op_q <= dec_class;
      if (state_reg == UC_DECODE && dec_illegal)
        illegal_reg <= 1'b1;
      else if (state_reg == UC_HALT && start)
        illegal_reg <= 1'b0;
    end
  end

  // Outputs decode state and op_q; an asserted reset overrides them at once so
  // a write in flight is dropped in the cycle reset is seen.
  always_comb begin
    pc_load        = 1'b0;
    pc_reset       = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    reg_file_write = 1'b0;
    alu_op         = ALUOP_ADD;
    select_mux_1   = MUX1_RS2;
    select_mux_2   = MUX2_ALU;
    select_mux_3   = MUX3_PC1;
    select_mux_4   = MUX4_ALU;
    busy           = 1'b0;
    halted         = 1'b0;
    illegal        = illegal_reg;
    case (state_reg)
      UC_IDLE:   pc_reset = 1'b1;
      UC_FETCH:  busy = 1'b1;
      UC_DECODE: busy = 1'b1;
      UC_EXEC, UC_WB: begin
        busy = 1'b1;
        case (op_q)
          OP_R:      alu_op = ALUOP_R;
          OP_I:      begin alu_op = ALUOP_I; select_mux_1 = MUX1_IMM; end
          OP_LOAD,
          OP_STORE:  begin alu_op = ALUOP_ADD; select_mux_1 = MUX1_IMM; end
          OP_BRANCH: begin
            alu_op       = ALUOP_BR;
            pc_load      = 1'b1;
            select_mux_3 = branch ? MUX3_PCIMM : MUX3_PC1;
          end
          default:   ;
        endcase
        if (state_reg == UC_WB) begin
          reg_file_write = 1'b1;
          pc_load        = 1'b1;
          select_mux_3   = MUX3_PC1;
          select_mux_2   = (op_q == OP_LOAD) ? MUX2_MEM : MUX2_ALU;
        end
      end
      UC_MEM: begin
        busy         = 1'b1;
        alu_op       = ALUOP_ADD;
        select_mux_1 = MUX1_IMM;
        if (op_q == OP_LOAD) begin
          mem_re = 1'b1;
        end else begin
          mem_we       = 1'b1;
          select_mux_4 = MUX4_RS2;
          pc_load      = 1'b1;
        end
      end
      UC_HALT:   halted = 1'b1;
      default:   ;
    endcase
    if (!reset) begin
      pc_load        = 1'b0;
      pc_reset       = 1'b1;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      reg_file_write = 1'b0;
      alu_op         = ALUOP_ADD;
      select_mux_1   = MUX1_RS2;
      select_mux_2   = MUX2_ALU;
      select_mux_3   = MUX3_PC1;
      select_mux_4   = MUX4_ALU;
      busy           = 1'b0;
      halted         = 1'b0;
      illegal        = 1'b0;
    end
  end

`ifdef RISCV_UC_PERF_EN
  logic retire;
  assign retire = (state_next == UC_FETCH) &&
                  (state_reg == UC_EXEC || state_reg == UC_MEM || state_reg == UC_WB);

  always_ff @(posedge clk) begin
    if (!reset || state_next == UC_IDLE) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_reg != UC_IDLE && state_reg != UC_HALT) cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (retire) instret_cnt <= instret_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_uc.sv
// Table-driven check of the riscv_uc control unit: one row per clock cycle,
// plus a hand-written check that reset clears the latched opcode class.
module tb_riscv_uc;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [6:0] opcode = OPC_R;
  logic       branch = 1'b0;
  logic       pc_load, pc_reset, mem_re, mem_we, reg_file_write;
  logic [1:0] alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4;
  logic       busy, halted, illegal;
`ifdef RISCV_UC_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  riscv_uc #(.AUTO_START(1'b0), .PERF_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .opcode         (opcode),
    .branch         (branch),
    .pc_load        (pc_load),
    .pc_reset       (pc_reset),
    .mem_re         (mem_re),
    .mem_we         (mem_we),
    .reg_file_write (reg_file_write),
    .alu_op         (alu_op),
    .select_mux_1   (select_mux_1),
    .select_mux_2   (select_mux_2),
    .select_mux_3   (select_mux_3),
    .select_mux_4   (select_mux_4),
    .busy           (busy),
    .halted         (halted),
    .illegal        (illegal)
`ifdef RISCV_UC_PERF_EN
    ,
    .cycle_cnt      (cycle_cnt),
    .instret_cnt    (instret_cnt)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        st;
    logic [6:0]  opc;
    logic        br;
    logic [17:0] exp;
    string       tag;
    bit          chk_perf;
    int unsigned exp_cyc;
    int unsigned exp_ret;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // {pc_load, pc_reset, mem_re, mem_we, rfw, alu_op, mux1..mux4, busy, halted, illegal}
  function automatic logic [17:0] ev(input logic pl, pr, re, we, rw,
                                     input logic [1:0] alu, m1, m2, m3, m4,
                                     input logic bz, hl, il);
    return {pl, pr, re, we, rw, alu, m1, m2, m3, m4, bz, hl, il};
  endfunction

  task automatic add(input logic rst_n, st, input logic [6:0] opc,
                     input logic br, input logic [17:0] exp, input string tag);
    vec_t v;
    v.rst_n = rst_n; v.st = st; v.opc = opc; v.br = br; v.exp = exp; v.tag = tag;
    v.chk_perf = 1'b0; v.exp_cyc = 0; v.exp_ret = 0;
    vecs.push_back(v);
  endtask

  task automatic perf_last(input int unsigned cyc, input int unsigned ret);
    vecs[vecs.size()-1].chk_perf = 1'b1;
    vecs[vecs.size()-1].exp_cyc  = cyc;
    vecs[vecs.size()-1].exp_ret  = ret;
  endtask

  logic [17:0] e_idle, e_busy, e_ex_r, e_wb_r, e_ex_i, e_wb_i, e_ex_ls;
  logic [17:0] e_mem_ld, e_wb_ld, e_mem_st, e_ex_b1, e_ex_b0, e_halt_il, e_halt;
  logic [17:0] act;

  initial begin
    e_idle    = ev(0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0);
    e_busy    = ev(0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 1,0,0);
    e_ex_r    = ev(0,0,0,0,0, 2'd2,2'd0,2'd0,2'd0,2'd0, 1,0,0);
    e_wb_r    = ev(1,0,0,0,1, 2'd2,2'd0,2'd0,2'd0,2'd0, 1,0,0);
    e_ex_i    = ev(0,0,0,0,0, 2'd3,2'd1,2'd0,2'd0,2'd0, 1,0,0);
    e_wb_i    = ev(1,0,0,0,1, 2'd3,2'd1,2'd0,2'd0,2'd0, 1,0,0);
    e_ex_ls   = ev(0,0,0,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0, 1,0,0);
    e_mem_ld  = ev(0,0,1,0,0, 2'd0,2'd1,2'd0,2'd0,2'd0, 1,0,0);
    e_wb_ld   = ev(1,0,0,0,1, 2'd0,2'd1,2'd1,2'd0,2'd0, 1,0,0);
    e_mem_st  = ev(1,0,0,1,0, 2'd0,2'd1,2'd0,2'd0,2'd1, 1,0,0);
    e_ex_b1   = ev(1,0,0,0,0, 2'd1,2'd0,2'd0,2'd1,2'd0, 1,0,0);
    e_ex_b0   = ev(1,0,0,0,0, 2'd1,2'd0,2'd0,2'd0,2'd0, 1,0,0);
    e_halt_il = ev(0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,1,1);
    e_halt    = ev(0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0, 0,1,0);

    // Reset for two cycles, then idle until start.
    add(0,0,OPC_R,0, e_idle, "rst0");
    add(0,0,OPC_R,0, e_idle, "rst1");
    add(1,0,OPC_R,0, e_idle, "idle0");
    add(1,0,OPC_R,0, e_idle, "idle1");
    add(1,1,OPC_R,0, e_idle, "idle_start");
    // R-type: 4 cycles
    add(1,0,OPC_R,0, e_busy, "r_fetch");
    add(1,0,OPC_R,0, e_busy, "r_decode");
    add(1,0,OPC_R,0, e_ex_r, "r_exec");
    add(1,0,OPC_R,0, e_wb_r, "r_wb");
    // I-type: 4 cycles; start while busy must be ignored
    add(1,1,OPC_I,0, e_busy, "i_fetch");   perf_last(4, 1);
    add(1,0,OPC_I,0, e_busy, "i_decode");
    add(1,0,OPC_I,0, e_ex_i, "i_exec");
    add(1,0,OPC_I,0, e_wb_i, "i_wb");
    // LOAD: 5 cycles
    add(1,0,OPC_LOAD,0, e_busy,   "ld_fetch"); perf_last(8, 2);
    add(1,0,OPC_LOAD,0, e_busy,   "ld_decode");
    add(1,0,OPC_LOAD,0, e_ex_ls,  "ld_exec");
    add(1,0,OPC_LOAD,0, e_mem_ld, "ld_mem");
    add(1,0,OPC_LOAD,0, e_wb_ld,  "ld_wb");
    // STORE: 4 cycles
    add(1,0,OPC_STORE,0, e_busy,   "st_fetch"); perf_last(13, 3);
    add(1,0,OPC_STORE,0, e_busy,   "st_decode");
    add(1,0,OPC_STORE,0, e_ex_ls,  "st_exec");
    add(1,0,OPC_STORE,0, e_mem_st, "st_mem");
    // Branch taken / not taken: 3 cycles each
    add(1,0,OPC_BRANCH,1, e_busy,  "bt_fetch"); perf_last(17, 4);
    add(1,0,OPC_BRANCH,1, e_busy,  "bt_decode");
    add(1,0,OPC_BRANCH,1, e_ex_b1, "bt_exec");
    add(1,0,OPC_BRANCH,0, e_busy,  "bn_fetch");
    add(1,0,OPC_BRANCH,0, e_busy,  "bn_decode");
    add(1,0,OPC_BRANCH,0, e_ex_b0, "bn_exec");
    // Illegal opcode: HALT with illegal set, nothing written for 10 cycles
    add(1,0,7'h7F,0, e_busy, "il_fetch"); perf_last(23, 6);
    add(1,0,7'h7F,0, e_busy, "il_decode");
    for (int k = 0; k < 10; k++) add(1,0,7'h7F,0, e_halt_il, "il_halt");
    add(1,1,7'h7F,0, e_halt_il, "il_halt_start");
    add(1,0,OPC_R,0, e_idle, "il_idle");
    add(1,0,OPC_R,0, e_idle, "il_idle2");
    // SYSTEM opcode: clean HALT
    add(1,1,OPC_SYSTEM,0, e_idle, "sys_start");
    add(1,0,OPC_SYSTEM,0, e_busy, "sys_fetch");
    add(1,0,OPC_SYSTEM,0, e_busy, "sys_decode");
    add(1,1,OPC_SYSTEM,0, e_halt, "sys_halt");
    add(1,0,OPC_R,0, e_idle, "sys_idle");
    // Reset during the MEM cycle of a store
    add(1,1,OPC_STORE,0, e_idle,  "sr_start");
    add(1,0,OPC_STORE,0, e_busy,  "sr_fetch");
    add(1,0,OPC_STORE,0, e_busy,  "sr_decode");
    add(1,0,OPC_STORE,0, e_ex_ls, "sr_exec");
    add(0,0,OPC_STORE,0, e_idle,  "sr_mem_rst");
    add(1,0,OPC_STORE,0, e_idle,  "sr_idle");

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset  = vecs[i].rst_n;
      start  = vecs[i].st;
      opcode = vecs[i].opc;
      branch = vecs[i].br;
      @(negedge clk);
      act = {pc_load, pc_reset, mem_re, mem_we, reg_file_write, alu_op,
             select_mux_1, select_mux_2, select_mux_3, select_mux_4,
             busy, halted, illegal};
      tests++;
      if (act !== vecs[i].exp) begin
        fails++;
        $display("FAIL row %0d %s: outputs got %b want %b", i, vecs[i].tag, act, vecs[i].exp);
      end else begin
        $display("[TB] row %0d %s outputs %b", i, vecs[i].tag, act);
      end
`ifdef RISCV_UC_PERF_EN
      if (vecs[i].chk_perf) begin
        tests++;
        if (cycle_cnt !== vecs[i].exp_cyc || instret_cnt !== vecs[i].exp_ret) begin
          fails++;
          $display("FAIL row %0d %s perf: cycle %0d instret %0d want %0d %0d",
                   i, vecs[i].tag, cycle_cnt, instret_cnt, vecs[i].exp_cyc, vecs[i].exp_ret);
        end
      end
`endif
    end

    // Latched opcode class must be cleared by the mid-store reset.
    tests++;
    if (dut.op_q !== OP_NONE) begin
      fails++;
      $display("FAIL op_q_after_reset: got %0d want %0d", dut.op_q, OP_NONE);
    end else begin
      $display("[TB] op_q_after_reset %0d", dut.op_q);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
